// File: rtl/keccak_chi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keccak_chi : slice-serial Chi step of Keccak-f[1600], one slice/cycle    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module keccak_chi #(
  parameter int SLICES = 64,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [24:0] in,
  output logic [24:0] out,
  output logic        outValid,
  output logic        putInput,
  output logic        ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SLICES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [24:0]      r_out;
  logic             r_valid;
  logic [24:0]      w_chi;
  logic             w_last;

  // Each row of five bits is treated as a ring: bit x combines x+1 and x+2.
  for (genvar y = 0; y < 5; y++) begin : g_row
    logic [4:0] w_row;
    assign w_row = in[5*y +: 5];
    assign w_chi[5*y +: 5] = w_row ^ (~{w_row[0], w_row[4:1]} & {w_row[1:0], w_row[4:2]});
  end

  assign w_last = (r_cnt == C_LAST);

  always_comb begin
    w_next   = r_state;
    putInput = 1'b0;
    ready    = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_next = S_INIT;
      S_INIT:  w_next = S_RUN;
      S_RUN: begin
        putInput = 1'b1;
        if (w_last) w_next = S_FLUSH;
      end
      S_FLUSH: w_next = S_DONE;
      S_DONE: begin
        ready  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_INIT: begin
          r_cnt   <= '0;
          r_out   <= '0;
          r_valid <= 1'b0;
        end
        S_RUN: begin
          r_out   <= w_chi;
          r_valid <= 1'b1;
          // Counter parks on the last slice; only INIT rewinds it.
          if (!w_last) r_cnt <= r_cnt + 1'b1;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign out      = r_out;
  assign outValid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_keccak_chi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_keccak_chi : randomized bench for keccak_chi against a Chi model      |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_keccak_chi;

  localparam int SLICES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [24:0] din;
  logic [24:0] dout;
  logic        out_valid;
  logic        put_input;
  logic        ready;

  int checks = 0, failures = 0;
  int put_cnt = 0, valid_cnt = 0, ready_cnt = 0, run_len = 0;
  bit prev_put = 1'b0, prev_valid = 1'b0, drv_put = 1'b0;
  int mode = 0, idx = 0;
  logic [24:0] inq[$];

  always #5 clk = ~clk;

  keccak_chi #(.SLICES(SLICES), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in      (din),
    .out     (dout),
    .outValid(out_valid),
    .putInput(put_input),
    .ready   (ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] chi_ref(input logic [24:0] a);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        r[5*y+x] = a[5*y+x] ^ (~a[5*y+(x+1)%5] & a[5*y+(x+2)%5]);
    return r;
  endfunction

  function automatic logic [24:0] dir_exp(input logic [24:0] a);
    case (a)
      25'h1FFFFFF: return 25'h1FFFFFF;
      25'h0000002: return 25'h0000012;
      25'h0000001: return 25'h0000009;
      25'h0000040: return 25'h0000240;
      default:     return 25'h0;
    endcase
  endfunction

  function automatic logic [24:0] gen(input int m, input int k);
    case (m)
      0: return 25'h0;
      1: return 25'h1FFFFFF;
      3: return 25'(k);
      4: case (k % 4)
           0: return 25'h1FFFFFF;
           1: return 25'h0000002;
           2: return 25'h0000001;
           default: return 25'h0000040;
         endcase
      default: return 25'($urandom);
    endcase
  endfunction

  // Scoreboard: every sampled slice must come back as its Chi one cycle later.
  always @(negedge clk) begin
    logic [24:0] a;
    chk("valid_latency", 32'(out_valid), 32'(prev_put));
    if (out_valid) begin
      valid_cnt++;
      if (inq.size() == 0) chk("valid_without_input", 32'(1), 32'(0));
      else begin
        a = inq.pop_front();
        chk("chi_beat", 32'(dout), 32'(chi_ref(a)));
        if (mode == 4) chk("chi_directed", 32'(dout), 32'(dir_exp(a)));
      end
    end
    if (ready) begin
      ready_cnt++;
      chk("ready_position", 32'({prev_valid, out_valid}), 32'(2'b10));
      chk("ready_drained", 32'(inq.size()), 32'(0));
    end
    if (prev_put && !put_input) chk("put_run_len", 32'(run_len), 32'(SLICES));
    if (put_input && !rst) begin
      inq.push_back(din);
      put_cnt++;
      run_len++;
    end else run_len = 0;
    prev_valid = out_valid;
    prev_put   = put_input && !rst;
    if (rst) inq.delete();
  end

  task automatic drive_step();
    @(posedge clk); #1;
    if (put_input) begin
      if (!drv_put) idx = 0;
      din = gen(mode, idx);
      idx++;
    end
    drv_put = put_input;
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_out"}, 32'(dout), 32'(0));
    chk({tag, "_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_put"}, 32'(put_input), 32'(0));
    chk({tag, "_ready"}, 32'(ready), 32'(0));
  endtask

  task automatic run_pass(input int m, input bit glitch);
    int v0, p0, r0, n;
    v0 = valid_cnt; p0 = put_cnt; r0 = ready_cnt; n = 0;
    mode = m;
    start = 1'b1;
    drive_step();
    start = 1'b0;
    while (ready_cnt == r0 && n < 300) begin
      start = (glitch && drv_put && idx == 10);
      drive_step();
      n++;
    end
    start = 1'b0;
    chk("pass_timeout", 32'(n < 300), 32'(1));
    chk("pass_valid_beats", 32'(valid_cnt - v0), 32'(SLICES));
    chk("pass_put_cycles", 32'(put_cnt - p0), 32'(SLICES));
    chk("pass_ready_pulses", 32'(ready_cnt - r0), 32'(1));
    drive_step();
    drive_step();
  endtask

  initial begin
    int n, v0, r0;
    rst = 1'b1; start = 1'b0; din = '0;
    repeat (2) begin
      @(posedge clk); #1;
      idle_check("reset");
    end
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      idle_check("idle");
    end

    run_pass(0, 1'b0);
    run_pass(4, 1'b0);
    run_pass(1, 1'b0);
    run_pass(3, 1'b0);
    run_pass(2, 1'b0);
    run_pass(2, 1'b1);

    // Abort a pass right after slice 30 has been sampled.
    mode = 2; start = 1'b1;
    drive_step();
    start = 1'b0;
    n = 0;
    while (idx < 31 && n < 200) begin
      drive_step();
      n++;
    end
    chk("abort_reach_timeout", 32'(n < 200), 32'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drv_put = 1'b0;
    idle_check("abort");
    r0 = ready_cnt;
    repeat (5) drive_step();
    chk("abort_no_ready", 32'(ready_cnt - r0), 32'(0));
    run_pass(2, 1'b0);

    // Start held high: two back-to-back passes.
    v0 = valid_cnt; r0 = ready_cnt; n = 0;
    mode = 2; start = 1'b1;
    while (ready_cnt < r0 + 1 && n < 400) begin drive_step(); n++; end
    while (!put_input && n < 400) begin drive_step(); n++; end
    start = 1'b0;
    while (ready_cnt < r0 + 2 && n < 400) begin drive_step(); n++; end
    chk("b2b_timeout", 32'(n < 400), 32'(1));
    chk("b2b_valid_beats", 32'(valid_cnt - v0), 32'(2 * SLICES));
    chk("b2b_ready_pulses", 32'(ready_cnt - r0), 32'(2));
    repeat (4) drive_step();
    chk("final_idle_put", 32'(put_input), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
